// File: rtl/xeng_vacc_if.sv
// Streaming bus of the X-engine vector accumulator: MAC-chain samples in,
// integrated vectors out. The master drives samples; the slave accumulates.
interface xeng_vacc_if #(
   parameter int IN_WIDTH     = 12,
   parameter int ACC_WIDTH    = 32,
   parameter int N_SLOT_BITS  = 3,
   parameter int ACC_LEN_BITS = 16
);
   logic                      din_valid;
   logic [2*IN_WIDTH-1:0]     din;
   logic                      sync_in;
   logic [ACC_LEN_BITS-1:0]   acc_len;
   logic [2*ACC_WIDTH-1:0]    dout;
   logic                      dout_valid;
   logic [N_SLOT_BITS-1:0]    dout_idx;
   logic                      dout_sync;
   logic                      overflow;
   logic                      armed;

   modport master (
      output din_valid, din, sync_in, acc_len,
      input  dout, dout_valid, dout_idx, dout_sync, overflow, armed
   );

   modport slave (
      input  din_valid, din, sync_in, acc_len,
      output dout, dout_valid, dout_idx, dout_sync, overflow, armed
   );
endinterface

// File: rtl/xeng_vacc.sv
// X-engine vector accumulator: integrates N_SLOTS complex slots over a
// programmable number of vectors and streams out each integrated vector.

// One signed part (real or imag): optional restart, sign-extend, add, saturate.
module xeng_vacc_sat_add #(
   parameter int IN_WIDTH  = 12,
   parameter int ACC_WIDTH = 32
) (
   input  logic                 clr,
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [IN_WIDTH-1:0]  d,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 sat
);
   logic [ACC_WIDTH:0] ext;
   logic [ACC_WIDTH:0] base;
   logic [ACC_WIDTH:0] wide;

   // One guard bit catches overflow; clamp toward the sign of the true result.
   always_comb begin
      ext  = {{(ACC_WIDTH+1-IN_WIDTH){d[IN_WIDTH-1]}}, d};
      base = clr ? '0 : {acc[ACC_WIDTH-1], acc};
      wide = base + ext;
      sat  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
      if (sat)
         sum = {wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}};
      else
         sum = wide[ACC_WIDTH-1:0];
   end
endmodule

module xeng_vacc #(
   parameter int IN_WIDTH     = 12,
   parameter int ACC_WIDTH    = 32,
   parameter int N_SLOT_BITS  = 3,
   parameter int ACC_LEN_BITS = 16
) (
   input logic        clk,
   input logic        rst,
   xeng_vacc_if.slave bus
);
   localparam int N_SLOTS   = 1 << N_SLOT_BITS;
   localparam int NUM_PARTS = 2;  // part 1 = real (upper), part 0 = imag
   localparam logic [N_SLOT_BITS-1:0]  SLOT_ONE = 1;
   localparam logic [N_SLOT_BITS-1:0]  SLOT_MAX = '1;
   localparam logic [ACC_LEN_BITS-1:0] LEN_ONE  = 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                   state;
   logic [N_SLOT_BITS-1:0]   slot_cnt;
   logic [ACC_LEN_BITS-1:0]  vec_cnt;
   logic [ACC_LEN_BITS-1:0]  len;
   logic [2*ACC_WIDTH-1:0]   acc [N_SLOTS];

   logic                     sync_ok;
   logic                     take;
   logic [N_SLOT_BITS-1:0]   slot;
   logic [ACC_LEN_BITS-1:0]  vec;
   logic [ACC_LEN_BITS-1:0]  len_new;
   logic [ACC_LEN_BITS-1:0]  len_eff;
   logic                     first;
   logic                     last;
   logic [NUM_PARTS-1:0][ACC_WIDTH-1:0] acc_rd;
   logic [NUM_PARTS-1:0][ACC_WIDTH-1:0] sum;
   logic [NUM_PARTS-1:0]                sat;

   // An accepted sync re-aligns this very sample to slot 0 of vector 0 with
   // the freshly sampled length, so the position is muxed ahead of the adders.
   always_comb begin
      sync_ok = bus.sync_in & bus.din_valid;
      take    = bus.din_valid & (sync_ok | (state == ACCUM));
      len_new = (bus.acc_len == '0) ? LEN_ONE : bus.acc_len;
      slot    = sync_ok ? '0 : slot_cnt;
      vec     = sync_ok ? '0 : vec_cnt;
      len_eff = sync_ok ? len_new : len;
      first   = (vec == '0);
      last    = (vec == len_eff - LEN_ONE);
      acc_rd  = acc[slot];
   end

   for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
      xeng_vacc_sat_add #(
         .IN_WIDTH  (IN_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_part (
         .clr (first),
         .acc (acc_rd[p]),
         .d   (bus.din[p*IN_WIDTH +: IN_WIDTH]),
         .sum (sum[p]),
         .sat (sat[p])
      );
   end

   // Slot storage; contents are rewritten by the first vector, so no reset.
   always_ff @(posedge clk) begin
      if (take) acc[slot] <= sum;
   end

   // Control FSM: counters, sticky overflow and the registered dump outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         slot_cnt       <= '0;
         vec_cnt        <= '0;
         len            <= LEN_ONE;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout_idx   <= '0;
         bus.dout_sync  <= 1'b0;
         bus.overflow   <= 1'b0;
         bus.armed      <= 1'b0;
      end else begin
         bus.dout_valid <= 1'b0;
         bus.dout_sync  <= 1'b0;
         if (sync_ok) begin
            state     <= ACCUM;
            bus.armed <= 1'b1;
            len       <= len_new;
         end
         if (take) begin
            slot_cnt <= slot + SLOT_ONE;
            if (slot == SLOT_MAX)
               vec_cnt <= last ? '0 : vec + LEN_ONE;
            else
               vec_cnt <= vec;
            // A sync clears the flag, but its own saturation still counts.
            bus.overflow <= (sync_ok ? 1'b0 : bus.overflow) | (|sat);
            if (last) begin
               bus.dout       <= sum;
               bus.dout_valid <= 1'b1;
               bus.dout_idx   <= slot;
               bus.dout_sync  <= (slot == '0);
            end
         end
      end
   end
endmodule

// File: tb/tb_xeng_vacc.sv
// Self-checking bench for xeng_vacc: a sample-count based reference model
// predicts every cycle's outputs; a narrow-accumulator instance covers clamping.
module tb_xeng_vacc;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   xeng_vacc_if #(.IN_WIDTH(12), .ACC_WIDTH(32), .N_SLOT_BITS(3), .ACC_LEN_BITS(16)) bus ();
   xeng_vacc_if #(.IN_WIDTH(12), .ACC_WIDTH(12), .N_SLOT_BITS(3), .ACC_LEN_BITS(16)) sbus ();

   xeng_vacc #(.IN_WIDTH(12), .ACC_WIDTH(32), .N_SLOT_BITS(3), .ACC_LEN_BITS(16)) dut (
      .clk (clk), .rst (rst), .bus (bus));
   xeng_vacc #(.IN_WIDTH(12), .ACC_WIDTH(12), .N_SLOT_BITS(3), .ACC_LEN_BITS(16)) dut_sat (
      .clk (clk), .rst (rst), .bus (sbus));

   int n_chk = 0;
   int n_fail = 0;
   int n_dump = 0;

   // reference model: position = samples accepted since the last sync
   bit          m_armed;
   bit          m_ovf;
   int          m_k;
   int          m_len;
   longint      m_re [8];
   longint      m_im [8];
   bit          e_valid;
   bit          e_sync;
   logic [63:0] e_dout;
   logic [2:0]  e_idx;
   int          last_re;

   function automatic longint clamp(input longint x, output bit s);
      longint hi = (longint'(1) <<< 31) - 1;
      longint lo = -(longint'(1) <<< 31);
      s = 1'b0;
      if (x > hi) begin s = 1'b1; return hi; end
      if (x < lo) begin s = 1'b1; return lo; end
      return x;
   endfunction

   // Drive one cycle on the wide instance and predict its post-edge outputs.
   task automatic cyc(input bit v, input bit sy, input int re, input int im, input int len);
      int slot, vec;
      bit s1, s2;
      bus.din_valid = v;
      bus.sync_in   = sy;
      bus.din       = {re[11:0], im[11:0]};
      bus.acc_len   = len[15:0];
      e_valid = 1'b0;
      e_sync  = 1'b0;
      if (v && sy) begin
         m_armed = 1'b1; m_k = 0; m_len = (len == 0) ? 1 : len; m_ovf = 1'b0;
      end
      if (v && m_armed) begin
         slot = m_k % 8;
         vec  = m_k / 8;
         if (vec == 0) begin m_re[slot] = 0; m_im[slot] = 0; end
         m_re[slot] = clamp(m_re[slot] + re, s1);
         m_im[slot] = clamp(m_im[slot] + im, s2);
         if (s1 || s2) m_ovf = 1'b1;
         if (vec == m_len - 1) begin
            e_valid = 1'b1;
            e_sync  = (slot == 0);
            e_idx   = slot[2:0];
            e_dout  = {m_re[slot][31:0], m_im[slot][31:0]};
            n_dump++;
         end
         m_k = (m_k + 1) % (m_len * 8);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.din_valid = 0; bus.sync_in = 0; bus.din = '0; bus.acc_len = '0;
      sbus.din_valid = 0; sbus.sync_in = 0; sbus.din = '0; sbus.acc_len = '0;
      m_armed = 0; m_ovf = 0; m_k = 0; m_len = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({bus.dout, bus.dout_valid, bus.dout_idx, bus.dout_sync, bus.overflow, bus.armed} !== '0) begin
         n_fail++;
         $display("FAIL reset: got dout=%h v=%b idx=%0d s=%b ovf=%b arm=%b, want all zero",
                  bus.dout, bus.dout_valid, bus.dout_idx, bus.dout_sync, bus.overflow, bus.armed);
      end
      rst = 1'b0;
   endtask

   task automatic test_no_sync;
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 4);
         n_chk++;
         if (bus.dout_valid !== 1'b0 || bus.armed !== 1'b0) begin
            n_fail++;
            $display("FAIL no_sync: got v=%b arm=%b, want v=0 arm=0", bus.dout_valid, bus.armed);
         end
      end
   endtask

   task automatic test_basic;
      int d0 = n_dump;
      for (int v = 0; v < 8; v++) begin
         for (int s = 0; s < 8; s++) begin
            cyc(1, (v == 0 && s == 0), s + 1, -(s + 1), 4);
            n_chk++;
            if ({bus.dout_valid, bus.dout_sync, bus.overflow, bus.armed} !== {e_valid, e_sync, m_ovf, m_armed} ||
                (e_valid && {bus.dout, bus.dout_idx} !== {e_dout, e_idx})) begin
               n_fail++;
               $display("FAIL basic: got v=%b s=%b ovf=%b arm=%b dout=%h idx=%0d, want v=%b s=%b ovf=%b arm=%b dout=%h idx=%0d",
                        bus.dout_valid, bus.dout_sync, bus.overflow, bus.armed, bus.dout, bus.dout_idx,
                        e_valid, e_sync, m_ovf, m_armed, e_dout, e_idx);
            end
            if (bus.dout_valid) begin
               n_chk++;
               if (int'($signed(bus.dout[63:32])) !== 4 * (int'(bus.dout_idx) + 1) ||
                   int'($signed(bus.dout[31:0])) !== -4 * (int'(bus.dout_idx) + 1) ||
                   bus.dout_sync !== (bus.dout_idx == 3'd0)) begin
                  n_fail++;
                  $display("FAIL basic_val: idx=%0d got re=%0d im=%0d s=%b, want re=%0d im=%0d",
                           bus.dout_idx, $signed(bus.dout[63:32]), $signed(bus.dout[31:0]), bus.dout_sync,
                           4 * (int'(bus.dout_idx) + 1), -4 * (int'(bus.dout_idx) + 1));
               end
            end
         end
      end
      n_chk++;
      if (n_dump - d0 !== 16) begin
         n_fail++;
         $display("FAIL basic_count: got %0d dumps, want 16", n_dump - d0);
      end
   endtask

   task automatic test_len01;
      int re;
      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < 16; i++) begin
            re = (i == 0) ? -2048 : int'($urandom_range(0, 4095)) - 2048;
            last_re = re;
            cyc(1, (i == 0), re, int'($urandom_range(0, 4095)) - 2048, l);
            n_chk++;
            if ({bus.dout_valid, bus.dout_sync, bus.overflow, bus.armed} !== {e_valid, e_sync, m_ovf, m_armed} ||
                (e_valid && {bus.dout, bus.dout_idx} !== {e_dout, e_idx})) begin
               n_fail++;
               $display("FAIL len01: len=%0d got v=%b dout=%h idx=%0d, want v=%b dout=%h idx=%0d",
                        l, bus.dout_valid, bus.dout, bus.dout_idx, e_valid, e_dout, e_idx);
            end
            n_chk++;
            if (bus.dout_valid !== 1'b1 || int'($signed(bus.dout[63:32])) !== last_re) begin
               n_fail++;
               $display("FAIL len01_echo: len=%0d got v=%b re=%0d, want v=1 re=%0d",
                        l, bus.dout_valid, $signed(bus.dout[63:32]), last_re);
            end
         end
      end
   endtask

   task automatic test_saturate;
      for (int v = 0; v < 2; v++) begin
         for (int s = 0; s < 8; s++) begin
            sbus.din_valid = 1'b1;
            sbus.sync_in   = (v == 0 && s == 0);
            sbus.acc_len   = 16'd2;
            sbus.din       = (s == 0) ? {12'd2047, 12'd0} : 24'd0;
            @(posedge clk); @(negedge clk);
            if (v == 0 && s == 7) begin
               n_chk++;
               if (sbus.overflow !== 1'b0 || sbus.dout_valid !== 1'b0) begin
                  n_fail++;
                  $display("FAIL sat_pre: got ovf=%b v=%b, want ovf=0 v=0", sbus.overflow, sbus.dout_valid);
               end
            end
            if (v == 1 && s == 0) begin
               n_chk++;
               if (sbus.dout_valid !== 1'b1 || sbus.dout !== {12'd2047, 12'd0} || sbus.overflow !== 1'b1) begin
                  n_fail++;
                  $display("FAIL sat_clamp: got v=%b dout=%h ovf=%b, want v=1 dout=7ff000 ovf=1",
                           sbus.dout_valid, sbus.dout, sbus.overflow);
               end
            end
         end
      end
      n_chk++;
      if (sbus.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_sticky: got ovf=%b, want 1", sbus.overflow);
      end
      sbus.sync_in = 1'b1; sbus.din = '0;
      @(posedge clk); @(negedge clk);
      sbus.din_valid = 1'b0; sbus.sync_in = 1'b0;
      n_chk++;
      if (sbus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_clear: got ovf=%b, want 0", sbus.overflow);
      end
   endtask

   task automatic test_resync;
      int d0;
      for (int i = 0; i < 21; i++) begin
         cyc(1, (i == 0), 100 + i, -i, 4);
      end
      d0 = n_dump;
      for (int i = 0; i < 16; i++) begin
         cyc(1, (i == 0), int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 2);
         n_chk++;
         if ({bus.dout_valid, bus.dout_sync, bus.overflow, bus.armed} !== {e_valid, e_sync, m_ovf, m_armed} ||
             (e_valid && {bus.dout, bus.dout_idx} !== {e_dout, e_idx})) begin
            n_fail++;
            $display("FAIL resync: i=%0d got v=%b s=%b dout=%h idx=%0d, want v=%b s=%b dout=%h idx=%0d",
                     i, bus.dout_valid, bus.dout_sync, bus.dout, bus.dout_idx, e_valid, e_sync, e_dout, e_idx);
         end
      end
      n_chk++;
      if (n_dump - d0 !== 8) begin
         n_fail++;
         $display("FAIL resync_count: got %0d dumps, want 8", n_dump - d0);
      end
   endtask

   task automatic test_random;
      bit v, sy;
      for (int i = 0; i < 600; i++) begin
         v  = ($urandom % 2) == 0;
         sy = v && (($urandom % 48) == 0 || i == 0);
         cyc(v, sy, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 3)));
         n_chk++;
         if ({bus.dout_valid, bus.dout_sync, bus.overflow, bus.armed} !== {e_valid, e_sync, m_ovf, m_armed} ||
             (e_valid && {bus.dout, bus.dout_idx} !== {e_dout, e_idx})) begin
            n_fail++;
            $display("FAIL random: i=%0d got v=%b s=%b ovf=%b arm=%b dout=%h idx=%0d, want v=%b s=%b ovf=%b arm=%b dout=%h idx=%0d",
                     i, bus.dout_valid, bus.dout_sync, bus.overflow, bus.armed, bus.dout, bus.dout_idx,
                     e_valid, e_sync, m_ovf, m_armed, e_dout, e_idx);
         end
      end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 3; i++) cyc(1, (i == 0), 5, 7, 1);
      bus.din_valid = 1'b1; bus.sync_in = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if ({bus.dout, bus.dout_valid, bus.dout_idx, bus.dout_sync, bus.overflow, bus.armed} !== '0) begin
         n_fail++;
         $display("FAIL async_rst: got dout=%h v=%b idx=%0d s=%b ovf=%b arm=%b, want all zero",
                  bus.dout, bus.dout_valid, bus.dout_idx, bus.dout_sync, bus.overflow, bus.armed);
      end
      m_armed = 0; m_ovf = 0; m_k = 0; e_valid = 0; e_sync = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc(1, (i == 10), 3, -3, 1);
         n_chk++;
         if ({bus.dout_valid, bus.dout_sync, bus.overflow, bus.armed} !== {e_valid, e_sync, m_ovf, m_armed} ||
             (e_valid && {bus.dout, bus.dout_idx} !== {e_dout, e_idx})) begin
            n_fail++;
            $display("FAIL post_rst: i=%0d got v=%b arm=%b dout=%h idx=%0d, want v=%b arm=%b dout=%h idx=%0d",
                     i, bus.dout_valid, bus.armed, bus.dout, bus.dout_idx, e_valid, m_armed, e_dout, e_idx);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_no_sync;
      test_basic;
      test_len01;
      test_saturate;
      test_resync;
      test_random;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/xeng_vacc.md
# xeng_vacc

Vector accumulator sitting directly downstream of the DSP48E complex MAC chain in the X-engine. It consumes one complex cross-product per valid cycle, {real, imag} two's complement. It accumulates each of 2^N_SLOT_BITS slots, for example baselines or channels presented round-robin, over a programmable number of vectors, then streams out the integrated vector. The integration boundary is set by an external sync pulse.

## Interface
- IN_WIDTH, 12: width of each of the real/imag input parts, signed; matches the MAC chain output 2*BITWIDTH+1+N_INPUT_BITS for BITWIDTH=4, N_INPUT_BITS=3.
- ACC_WIDTH, 32: width of each of the real/imag accumulator and output parts, signed; must be ≥ IN_WIDTH.
- N_SLOT_BITS, 3: log2 of the slots per vector, giving N_SLOTS = 8.
- ACC_LEN_BITS, 16: width of the integration-length input.

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  din carries a sample this cycle
- din  in  2*IN_WIDTH  {real[2*IN_WIDTH-1:IN_WIDTH], imag[IN_WIDTH-1:0]}, signed
- sync_in  in  1  qualified by din_valid; marks slot 0 of the first vector of a new integration
- acc_len  in  ACC_LEN_BITS  vectors per integration; sampled only on an accepted sync; 0 treated as 1
- dout  out  2*ACC_WIDTH  {real, imag} integrated sum, signed
- dout_valid  out  1  dout/dout_idx valid
- dout_idx  out  N_SLOT_BITS  slot index of dout
- dout_sync  out  1  high with slot 0 of each dumped vector
- overflow  out  1  sticky; set on any saturation; cleared on accepted sync
- armed  out  1  high in ACCUM state

## Operation
- States:
  - IDLE (after reset): din discarded.
  - ACCUM: entered on accepted sync (sync_in & din_valid) from any state.
- Counters:
  - slot_cnt (N_SLOT_BITS) and vec_cnt (ACC_LEN_BITS), plus latched len = max(acc_len, 1).
  - Accepted sync forces slot_cnt=0 and vec_cnt=0; the sync sample itself is processed as slot 0.
  - Each accepted din in ACCUM advances slot_cnt, wrapping N_SLOTS-1→0.
  - On that wrap, vec_cnt increments; if vec_cnt==len-1 it becomes 0 instead.
- Storage: register array acc[N_SLOTS], each 2*ACC_WIDTH.
- Per accepted sample in slot s:
  - first = (vec_cnt==0); last = (vec_cnt==len-1).
  - Both parts are sign-extended to ACC_WIDTH.
  - sum = first ? ext(din) : acc[s]+ext(din), computed per part and saturated to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Saturation in either part sets overflow.
  - acc[s] <= sum.
  - If last: dout <= sum, dout_valid <= 1, dout_idx <= s, dout_sync <= (s==0).
- len=1: every vector is dumped unmodified, sign-extended.
- After a dump the integration restarts automatically with no sync needed; later syncs re-align.
- Sync mid-integration: partial sums abandoned, not dumped; new integration starts with the sync sample; acc_len re-sampled.
- Sync with slot_cnt≠0 is legal; alignment is forced to slot 0.
- sync_in without din_valid: ignored.
- din_valid gaps: all state holds; no output.
- Reset mid-operation: state → IDLE, counters 0, outputs cleared, acc contents don't-care (overwritten on first vector).

## Timing
- Latency: dout appears 1 clk after the accepted sample of the last vector (registered output).
- dout_valid is a one-cycle pulse per dumped sample; full throughput is one sample per clk; no back-pressure.
- Reset values: dout=0, dout_valid=0, dout_idx=0, dout_sync=0, overflow=0, armed=0.
- overflow clears in the cycle after an accepted sync, unless that sync sample itself saturates, in which case it stays set.
- armed rises the cycle after the first accepted sync.

## Test plan
- Reset, then 16 valid samples with no sync → no dout_valid, armed=0.
- Sync with acc_len=4, 4 vectors of slot s = {real=s+1, imag=-(s+1)} → after the 4th vector, 8 consecutive dout_valid with dout_idx 0..7, real=4(s+1), imag=-4(s+1), dout_sync only on idx 0, 1-cycle latency; the next 4 vectors give identical output with no new sync.
- acc_len=0 and acc_len=1 → every vector echoed sign-extended; din real=-2048 (0x800) → dout real=-2048.
- ACC_WIDTH=12, acc_len=2, real=2047 twice → dout real=2047 saturated, overflow=1; it stays 1 until the next sync, then 0.
- Sync at slot 5 of vector 2 of 4 → no dump of the partial; the next dump reflects only post-sync data, indices starting at 0.
- Random din_valid gaps (50%) versus a reference model; async rst asserted mid-vector → all outputs 0 immediately, IDLE until the next sync.
